sfft_bin_magnitude_reader: RTL and testbench
============================================

// Module: sfft_bin_magnitude_reader
// PURPOSE
//  Downstream neighbour of SFFT_Pipeline. Waits for a new FFT frame, then reads bins 0..FREQS-1
//  through the SFFT output port. It holds OutputBeingRead while reading and converts each
//  complex bin to an L1 magnitude. It buffers the frame and streams it to the peak finder
//  over a valid/ready interface, tagged with bin index and frame time.
// PARAMETERS
//  IN_W       `SFFT_OUTPUT_WIDTH   width of SFFT_OutReal / Output_Why (signed two's complement)
//  MAG_W      `FINAL_AMPL_WIDTH    output magnitude width
//  ADDR_W     `nFFT                SFFT output address width
//  BINS       `FREQS               bins read per frame (0..BINS-1, real-input symmetry)
//  BIN_W      `FREQ_WIDTH          bin index width
//  TIME_W     `TIME_COUNTER_WIDTH  frame time counter width
//  READ_LAT   1                    SFFT output read latency in cycles (address -> data)
// PORTS
//  clk              in   1        clock
//  reset            in   1        asynchronous, active-low reset
//  OutputValid      in   1        SFFT: level high while an unread frame is held
//  outputReadError  in   1        SFFT: frame overwritten during read
//  SFFT_OutReal     in   IN_W     real part of addressed bin
//  Output_Why       in   IN_W     imaginary part of addressed bin
//  output_address   out  ADDR_W   bin address to SFFT
//  OutputBeingRead  out  1        holds SFFT output buffer while reading
//  mag_out          out  MAG_W    bin magnitude
//  bin_out          out  BIN_W    bin index of mag_out
//  time_out         out  TIME_W   frame number of mag_out
//  out_valid        out  1        stream valid
//  out_last         out  1        high with bin BINS-1
//  out_ready        in   1        downstream ready
//  dropped_frames   out  16       saturating count of aborted or skipped frames
//  busy             out  1        state != IDLE
// BEHAVIOUR
//  Reset (async, active-low): every output is 0, state IDLE, pending=0, frame time=0.
//  Frame trigger: OutputValid rising edge, registered edge detect.
//    In IDLE, a trigger enters READ on the next cycle.
//    In READ or EMIT, a trigger sets pending=1.
//    A trigger while pending=1 increments dropped_frames.
//  READ:
//    - Cycle k drives output_address=k, for k=0..BINS-1.
//    - Data for address k is captured at cycle k+READ_LAT into buf[k].
//    - OutputBeingRead is high from the first READ cycle through the last capture
//      (BINS+READ_LAT cycles).
//    - After the last capture, go to EMIT.
//  Read abort: outputReadError high in any READ cycle ->
//    - drop OutputBeingRead, dropped_frames++;
//    - frame time unchanged, nothing emitted, return to IDLE (or READ if pending).
//  Magnitude: mag = sat_MAG(|re| + |im|).
//    - |x| of -2^(IN_W-1) saturates to 2^(IN_W-1)-1.
//    - The sum is IN_W+1 bits; it clamps to all-ones if it exceeds MAG_W.
//  EMIT:
//    - Present buf[i], bin_out=i, time_out=frame time, out_valid=1, starting at i=0.
//    - Advance i only when out_valid && out_ready.
//    - Outputs are held stable while stalled.
//    - out_last=1 with i=BINS-1.
//    - After the last handshake: frame time++ (wraps); go to READ if pending (clear it),
//      else IDLE; out_valid=0.
//  The SFFT output port is idle (OutputBeingRead=0) during EMIT, so SFFT may advance meanwhile.
//  Latency: first out_valid 1+BINS+READ_LAT+1 cycles after the OutputValid rising edge.
// STRUCTURE
//  Shared package sfft_pkg: state enum {IDLE, READ, EMIT}; function sat_abs(); function sat_add().
//  Sub-module sfft_mag_l1 (combinational abs + add + saturate). The BINS x MAG_W buffer is
//  inferred as registers.
// TESTING (NFFT=32, BINS=16, IN_W=MAG_W=32, READ_LAT=1; SFFT output modelled as a 1-cycle-latency RAM)
//  1 Reset: hold reset=0 and toggle inputs -> every output is 0.
//    Release, raise OutputValid -> first out_valid 19 cycles later.
//  2 RAM re[k]=10k, im[k]=-3k, out_ready=1 ->
//    - addresses 0..15 on consecutive cycles, OutputBeingRead high for 17 cycles;
//    - stream mag=13k, bin=k, time=0, out_last on k=15;
//    - second frame has time=1.
//  3 Same data, out_ready alternating 1/0 -> each bin appears exactly once, in order;
//    outputs are stable while out_ready=0.
//  4 re=0x80000000, im=0x7FFFFFFF at bin 3 -> mag_out=0xFFFFFFFE.
//    re=0, im=0 at bin 0 -> mag_out=0.
//  5 outputReadError pulse while address=7 ->
//    - no out_valid for that frame, dropped_frames=1;
//    - next good frame emits with time=0.
//  6 Two triggers during EMIT -> dropped_frames=1, one READ starts after out_last.
//    Reset asserted mid-EMIT at bin 5 -> out_valid falls immediately; the next frame
//    restarts at bin 0, time 0.

Source files
------------

// File: rtl/sfft_pkg.sv
// rtl/sfft_pkg.sv - shared state type and saturating helpers for the SFFT bin magnitude reader
package sfft_pkg;

  typedef enum logic [1:0] {IDLE, READ, EMIT} state_t;

  localparam int MAX_W = 64;

  // x is a w-bit two's complement value sign-extended to MAX_W bits
  function automatic logic [MAX_W-1:0] sat_abs(input logic [MAX_W-1:0] x, input int w);
    logic [MAX_W-1:0] lim;
    logic [MAX_W-1:0] a;
    lim = (MAX_W'(1) << (w - 1)) - MAX_W'(1);
    a = x[MAX_W-1] ? (~x + MAX_W'(1)) : x;
    return (a > lim) ? lim : a;
  endfunction

  function automatic logic [MAX_W-1:0] sat_add(input logic [MAX_W-1:0] a, input logic [MAX_W-1:0] b,
                                               input int w);
    logic [MAX_W-1:0] lim;
    logic [MAX_W-1:0] s;
    lim = (MAX_W'(1) << w) - MAX_W'(1);
    s = a + b;
    return (s > lim) ? lim : s;
  endfunction

endpackage

// File: rtl/sfft_mag_l1.sv
// rtl/sfft_mag_l1.sv - combinational saturating L1 magnitude |re| + |im| of one complex bin
module sfft_mag_l1
  import sfft_pkg::*;
#(
  parameter int IN_W  = 32,
  parameter int MAG_W = 32
) (
  input  logic [IN_W-1:0]  re,
  input  logic [IN_W-1:0]  im,
  output logic [MAG_W-1:0] mag
);

  logic [MAX_W-1:0] re_x;
  logic [MAX_W-1:0] im_x;
  logic [MAX_W-1:0] sum;
  logic             unused_hi;

  assign re_x = {{(MAX_W-IN_W){re[IN_W-1]}}, re};
  assign im_x = {{(MAX_W-IN_W){im[IN_W-1]}}, im};
  assign sum  = sat_add(sat_abs(re_x, IN_W), sat_abs(im_x, IN_W), MAG_W);
  assign mag  = sum[MAG_W-1:0];
  assign unused_hi = ^sum[MAX_W-1:MAG_W];

endmodule

// File: rtl/sfft_bin_magnitude_reader.sv
// rtl/sfft_bin_magnitude_reader.sv - reads one SFFT frame per trigger, buffers L1 magnitudes
// and streams them with bin index and frame time.
module sfft_bin_magnitude_reader
  import sfft_pkg::*;
#(
  parameter int IN_W     = 32,
  parameter int MAG_W    = 32,
  parameter int ADDR_W   = 5,
  parameter int BINS     = 16,
  parameter int BIN_W    = 4,
  parameter int TIME_W   = 16,
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              OutputValid,
  input  logic              outputReadError,
  input  logic [IN_W-1:0]   SFFT_OutReal,
  input  logic [IN_W-1:0]   Output_Why,
  output logic [ADDR_W-1:0] output_address,
  output logic              OutputBeingRead,
  output logic [MAG_W-1:0]  mag_out,
  output logic [BIN_W-1:0]  bin_out,
  output logic [TIME_W-1:0] time_out,
  output logic              out_valid,
  output logic              out_last,
  input  logic              out_ready,
  output logic [15:0]       dropped_frames,
  output logic              busy
);

  localparam int RD_CYC = BINS + READ_LAT;
  localparam int CNT_W  = $clog2(RD_CYC + 1);
  localparam int IDX_W  = $clog2(BINS);

  state_t            state;
  logic              ov_q;
  logic              trig;
  logic              pending;
  logic [CNT_W-1:0]  rd_cnt;
  logic [CNT_W-1:0]  cap_idx;
  logic [TIME_W-1:0] frame_time;
  logic [MAG_W-1:0]  mag;
  logic [MAG_W-1:0]  mag_buf [BINS];

  logic abort, rd_done, last_hs, restart, drop_trig, cap_en;

  sfft_mag_l1 #(.IN_W(IN_W), .MAG_W(MAG_W)) u_mag (
    .re  (SFFT_OutReal),
    .im  (Output_Why),
    .mag (mag)
  );

  assign abort     = (state == READ) && outputReadError;
  assign rd_done   = (state == READ) && (rd_cnt == CNT_W'(RD_CYC - 1));
  assign last_hs   = (state == EMIT) && out_valid && out_ready && out_last;
  // A frame end consumes either the pending trigger or one arriving in the same cycle
  assign restart   = (abort || last_hs) && (pending || trig);
  assign drop_trig = trig && pending && !(abort || last_hs);
  assign cap_en    = (state == READ) && !outputReadError && (rd_cnt >= CNT_W'(READ_LAT));
  assign cap_idx   = rd_cnt - CNT_W'(READ_LAT);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (cap_en) mag_buf[IDX_W'(cap_idx)] <= mag;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= IDLE;
      ov_q            <= 1'b0;
      trig            <= 1'b0;
      pending         <= 1'b0;
      rd_cnt          <= '0;
      frame_time      <= '0;
      output_address  <= '0;
      OutputBeingRead <= 1'b0;
      mag_out         <= '0;
      bin_out         <= '0;
      time_out        <= '0;
      out_valid       <= 1'b0;
      out_last        <= 1'b0;
      dropped_frames  <= '0;
    end else begin
      ov_q <= OutputValid;
      trig <= OutputValid && !ov_q;
      if ((abort || drop_trig) && dropped_frames != 16'hFFFF) dropped_frames <= dropped_frames + 16'd1;
      if (state != IDLE) begin
        if (abort || last_hs) pending <= pending && trig;
        else if (trig)        pending <= 1'b1;
      end
      case (state)
        IDLE: if (trig) begin
          state           <= READ;
          rd_cnt          <= '0;
          output_address  <= '0;
          OutputBeingRead <= 1'b1;
        end
        READ: begin
          if (abort) begin
            state           <= restart ? READ : IDLE;
            rd_cnt          <= '0;
            output_address  <= '0;
            OutputBeingRead <= restart;
          end else begin
            rd_cnt <= rd_cnt + 1'b1;
            if (output_address != ADDR_W'(BINS - 1)) output_address <= output_address + 1'b1;
            if (rd_done) begin
              state           <= EMIT;
              OutputBeingRead <= 1'b0;
              out_valid       <= 1'b1;
              out_last        <= 1'b0;
              bin_out         <= '0;
              mag_out         <= mag_buf[0];
              time_out        <= frame_time;
            end
          end
        end
        EMIT: if (out_valid && out_ready) begin
          if (out_last) begin
            out_valid       <= 1'b0;
            out_last        <= 1'b0;
            frame_time      <= frame_time + 1'b1;
            state           <= restart ? READ : IDLE;
            rd_cnt          <= '0;
            output_address  <= '0;
            OutputBeingRead <= restart;
          end else begin
            bin_out  <= bin_out + 1'b1;
            mag_out  <= mag_buf[IDX_W'(bin_out + 1'b1)];
            out_last <= (bin_out == BIN_W'(BINS - 2));
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sfft_bin_magnitude_reader.sv
// tb/tb_sfft_bin_magnitude_reader.sv - directed bench with a frame-level scoreboard model
module tb_sfft_bin_magnitude_reader;

  logic        clk, reset, OutputValid, outputReadError, out_ready;
  logic [31:0] ram_re, ram_im, mag_out;
  logic [4:0]  output_address;
  logic        OutputBeingRead, out_valid, out_last, busy;
  logic [3:0]  bin_out;
  logic [15:0] time_out, dropped_frames;

  sfft_bin_magnitude_reader #(
    .IN_W(32), .MAG_W(32), .ADDR_W(5), .BINS(16), .BIN_W(4), .TIME_W(16), .READ_LAT(1)
  ) dut (
    .clk(clk), .reset(reset), .OutputValid(OutputValid), .outputReadError(outputReadError),
    .SFFT_OutReal(ram_re), .Output_Why(ram_im), .output_address(output_address),
    .OutputBeingRead(OutputBeingRead), .mag_out(mag_out), .bin_out(bin_out),
    .time_out(time_out), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .dropped_frames(dropped_frames), .busy(busy)
  );

  typedef struct {logic [31:0] mag; logic [3:0] bin; logic [15:0] tm;} exp_t;

  exp_t        q[$];
  logic [31:0] re_mem [32];
  logic [31:0] im_mem [32];
  logic [31:0] seen_mag [16];
  logic [15:0] seen_time;
  logic [15:0] exp_time;
  int          checks, passes, hs_count, ready_mode;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    ram_re <= re_mem[output_address];
    ram_im <= im_mem[output_address];
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        default: out_ready = 1'b0;
      endcase
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d", checks);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [31:0] model_mag(input logic [31:0] re, input logic [31:0] im);
    longint a, b, s;
    a = longint'($signed(re));
    b = longint'($signed(im));
    if (a < 0) a = -a;
    if (b < 0) b = -b;
    if (a > 64'sd2147483647) a = 64'sd2147483647;
    if (b > 64'sd2147483647) b = 64'sd2147483647;
    s = a + b;
    if (s > 64'sd4294967295) s = 64'sd4294967295;
    return s[31:0];
  endfunction

  task automatic push_frame(input logic [15:0] tm);
    for (int k = 0; k < 16; k++)
      q.push_back('{mag: model_mag(re_mem[k], im_mem[k]), bin: 4'(k), tm: tm});
  endtask

  always @(negedge clk) begin
    if (reset && out_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_valid", 64'(out_valid), 64'd0);
      end else begin
        chk("mag", 64'(mag_out), 64'(q[0].mag));
        chk("bin", 64'(bin_out), 64'(q[0].bin));
        chk("time", 64'(time_out), 64'(q[0].tm));
        chk("last", 64'(out_last), 64'(q[0].bin == 4'd15));
        seen_mag[bin_out] = mag_out;
        seen_time = time_out;
        if (out_ready) begin
          void'(q.pop_front());
          hs_count++;
        end
      end
    end
  end

  task automatic apply_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    OutputValid = 1'b0;
    outputReadError = 1'b0;
    q.delete();
    exp_time = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  // err_addr < 0: good frame expected on the stream; otherwise abort when that address is read
  task automatic run_frame(input int err_addr, input bit check_lat);
    int cyc, obr_cnt, first_v;
    bit done, aborted;
    if (err_addr < 0) push_frame(exp_time);
    @(posedge clk);
    #1 OutputValid = 1'b1;
    cyc = -1; obr_cnt = 0; first_v = -1; done = 0; aborted = 0;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (cyc == 3) OutputValid = 1'b0;
      if (OutputBeingRead) begin
        if (obr_cnt < 16) chk("address", 64'(output_address), 64'(obr_cnt));
        obr_cnt++;
        if (err_addr >= 0 && !aborted && int'(output_address) == err_addr) begin
          outputReadError = 1'b1;
          aborted = 1;
        end
      end else if (outputReadError) begin
        outputReadError = 1'b0;
      end
      if (out_valid && first_v < 0) first_v = cyc;
      if (err_addr < 0) done = out_valid && out_ready && out_last;
      else done = (cyc >= 40);
    end
    if (err_addr < 0) begin
      chk("frame_done", 64'(done), 64'd1);
      if (check_lat) chk("latency", 64'(first_v), 64'd19);
      chk("obr_cycles", 64'(obr_cnt), 64'd17);
      exp_time++;
      @(posedge clk);
      @(negedge clk);
      chk("idle_after_frame", 64'(busy), 64'd0);
      chk("queue_drained", 64'(q.size()), 64'd0);
    end else begin
      chk("abort_obr_cycles", 64'(obr_cnt), 64'd8);
      chk("abort_no_valid", 64'(first_v), 64'hFFFF_FFFF_FFFF_FFFF);
      chk("abort_idle", 64'(busy), 64'd0);
    end
  endtask

  initial begin
    int n, rises, hs0;
    logic prev_obr;
    checks = 0; passes = 0; hs_count = 0; ready_mode = 0; exp_time = '0; seen_time = '0;
    reset = 1'b0; OutputValid = 1'b0; outputReadError = 1'b0;
    for (int k = 0; k < 32; k++) begin
      re_mem[k] = 32'(10 * k);
      im_mem[k] = 32'(-3 * k);
    end
    for (int k = 0; k < 16; k++) seen_mag[k] = '0;

    chk("model_pin_13k", 64'(model_mag(32'd50, 32'hFFFF_FFF1)), 64'd65);
    chk("model_pin_sat", 64'(model_mag(32'h8000_0000, 32'h7FFF_FFFF)), 64'hFFFF_FFFE);

    repeat (6) begin
      @(posedge clk);
      #1;
      OutputValid = 1'($urandom_range(0, 1));
      outputReadError = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("reset_mag", 64'(mag_out), 64'd0);
      chk("reset_ctrl", 64'({output_address, OutputBeingRead, bin_out, time_out, out_valid,
                             out_last, dropped_frames, busy}), 64'd0);
    end
    OutputValid = 1'b0;
    outputReadError = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;

    run_frame(-1, 1);
    chk("bin5_mag", 64'(seen_mag[5]), 64'd65);
    chk("bin15_mag", 64'(seen_mag[15]), 64'd195);
    chk("first_time", 64'(seen_time), 64'd0);
    run_frame(-1, 1);
    chk("second_time", 64'(seen_time), 64'd1);

    ready_mode = 1;
    hs0 = hs_count;
    run_frame(-1, 1);
    chk("stall_handshakes", 64'(hs_count - hs0), 64'd16);
    ready_mode = 0;

    re_mem[3] = 32'h8000_0000;
    im_mem[3] = 32'h7FFF_FFFF;
    seen_mag[3] = '0;
    seen_mag[0] = '1;
    run_frame(-1, 0);
    chk("sat_bin3", 64'(seen_mag[3]), 64'hFFFF_FFFE);
    chk("zero_bin0", 64'(seen_mag[0]), 64'd0);

    apply_reset();
    chk("dropped_after_reset", 64'(dropped_frames), 64'd0);
    run_frame(7, 0);
    chk("dropped_abort", 64'(dropped_frames), 64'd1);
    run_frame(-1, 1);
    chk("time_after_abort", 64'(seen_time), 64'd0);

    apply_reset();
    ready_mode = 2;
    push_frame(16'd0);
    @(posedge clk);
    #1 OutputValid = 1'b1;
    repeat (3) @(posedge clk);
    #1 OutputValid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("emit_reached", 64'(out_valid), 64'd1);
    for (int t = 0; t < 2; t++) begin
      @(posedge clk);
      #1 OutputValid = 1'b1;
      repeat (2) @(posedge clk);
      #1 OutputValid = 1'b0;
      repeat (2) @(posedge clk);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("dropped_two_triggers", 64'(dropped_frames), 64'd1);
    chk("stalled_bin", 64'(bin_out), 64'd0);
    push_frame(16'd1);
    ready_mode = 0;
    rises = 0;
    prev_obr = OutputBeingRead;
    n = 0;
    while ((q.size() != 0 || busy) && n < 300) begin
      @(negedge clk);
      n++;
      if (OutputBeingRead && !prev_obr) rises++;
      prev_obr = OutputBeingRead;
    end
    repeat (20) begin
      @(negedge clk);
      if (OutputBeingRead && !prev_obr) rises++;
      prev_obr = OutputBeingRead;
    end
    chk("pending_reads_once", 64'(rises), 64'd1);
    chk("pending_drained", 64'(q.size()), 64'd0);
    chk("pending_time", 64'(seen_time), 64'd1);

    push_frame(16'd2);
    @(posedge clk);
    #1 OutputValid = 1'b1;
    repeat (3) @(posedge clk);
    #1 OutputValid = 1'b0;
    n = 0;
    while (!(out_valid && bin_out == 4'd5) && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("reached_bin5", 64'(bin_out), 64'd5);
    #2 reset = 1'b0;
    #1;
    chk("valid_drops_on_reset", 64'(out_valid), 64'd0);
    chk("time_cleared_on_reset", 64'(time_out), 64'd0);
    q.delete();
    exp_time = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    run_frame(-1, 1);
    chk("restart_time", 64'(seen_time), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
